parallel_to_serial: RTL
=======================

# parallel_to_serial

Parallel-load, serial-out transmitter. It accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per clock on `out_s`. It drives `frame` high for exactly the bit periods of each word. It is the transmit end of the serial_to_parallel link: `out_s` feeds that block's `a` input and `frame` feeds its `start` input, so the word is rebuilt at the receiver after WIDTH clocks.

## Interface
- WIDTH, 8: word width in bits; legal range ≥ 2.
- MSB_FIRST, 0: bit order on the line. 0 = bit 0 first, which matches serial_to_parallel. 1 = bit WIDTH-1 first.

- clk  input  1  single clock; everything is sampled on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low. It forces all state and outputs to their reset values immediately.
- load  input  1  request to transmit `data_in`; sampled on the clk rising edge.
- data_in  input  WIDTH  word to send; sampled only on the edge where the load is accepted.
- in_ready  output  1  combinational; high when a load on the next edge will be accepted.
- out_s  output  1  registered serial data.
- frame  output  1  registered; high while `out_s` carries a valid bit.
- done  output  1  registered one-cycle pulse after the last bit of a word whose successor was not loaded.
- overrun  output  1  registered sticky flag; set when `load` arrives while `in_ready` is low. Cleared only by reset.

## Operation
- Internal state: FSM {IDLE, SHIFT}, a WIDTH-bit shift register `shreg`, and a bit counter `cnt` of width clog2(WIDTH).
- Reset values: state=IDLE, shreg=0, cnt=0, out_s=0, frame=0, done=0, overrun=0. `in_ready` reads 1 during reset.
- in_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1).
- Accept = load & in_ready. On the accept edge:
  - out_s ← first bit (data_in[0], or data_in[WIDTH-1] when MSB_FIRST=1).
  - shreg ← remaining bits, with the next bit positioned for output.
  - cnt ← 0, frame ← 1, state ← SHIFT.
- SHIFT with cnt < WIDTH-1: every edge, out_s ← next bit from shreg, shreg shifts by one toward the output end with zero fill, and cnt ← cnt+1. `load` is not accepted here.
- SHIFT with cnt == WIDTH-1, which is the last bit period:
  - If load is high: accept the new word as above. frame stays 1 with no gap, and done stays 0.
  - If load is low: out_s ← 0, frame ← 0, done ← 1, state ← IDLE.
- done is cleared on the edge after it is set, so it is always a single cycle.
- `load` while in_ready=0:
  - The request is ignored; the current word continues unchanged.
  - overrun ← 1 and stays 1 until reset.
- IDLE with no load: out_s=0, frame=0, and no state changes.
- data_in is don't-care on every edge except the accept edge. Changing it mid-word has no effect.

## Timing
- Latency: the first bit appears on out_s in the cycle immediately after the accept edge.
- Word duration: frame is high for exactly WIDTH consecutive cycles per word.
- Back-to-back loads give N·WIDTH consecutive cycles of frame=1.
- Throughput: one bit per clock, with no idle cycles required between words.
- done goes high in the cycle right after the last bit period, coinciding with the first cycle of frame=0.
- Receiver pairing: serial_to_parallel samples a on the edge that ends each bit period. Its register holds the full word on the edge after the final bit, and that edge coincides with done=1.
- Reset mid-word: out_s, frame, done and overrun go to 0 immediately without waiting for clk. The partial word is discarded. After rst_n rises, the first edge behaves as IDLE.
- Simultaneous load and reset: reset wins and the load is lost.

## Test plan
- Reset: hold rst_n=0 with clk toggling and load=1. Required response: out_s=0, frame=0, done=0, overrun=0, in_ready=1 throughout. Release rst_n asynchronously and check that no spurious frame follows.
- Single word, WIDTH=8, MSB_FIRST=0: load 8'hC1 for one cycle. Required response: on the following 8 cycles out_s = 1,0,0,0,0,0,1,1 with frame=1; then frame=0 and done=1 for exactly one cycle.
- Back-to-back: load 8'hA5, then hold load with 8'h3C in the last bit cycle. Required response: 16 continuous frame=1 cycles, out_s = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, and a single done pulse only after the second word.
- Overrun: load 8'hFF, then pulse load with 8'h00 at cnt=3. Required response: the 8'hFF bits are unchanged (eight 1s), overrun=1 from the next edge onward, and overrun stays set until rst_n is pulsed.
- MSB_FIRST=1, load 8'hC1. Required response: out_s = 1,1,0,0,0,0,0,1.
- Loopback and mid-word reset: connect the outputs to serial_to_parallel (out_s→a, frame→start, same clk). Load 8'h5A and check the receiver out_p=8'h5A on the done edge. Then load 8'hFF and assert rst_n low at cnt=4. Required response: frame drops immediately, and a fresh load of 8'h81 transmits correctly after reset release.

Source files
------------

// File: rtl/parallel_to_serial.sv
// parallel_to_serial
//   Parallel-load, serial-out transmitter. A WIDTH-bit word is accepted through
//   a load/in_ready handshake and shifted out one bit per clock on out_s, with
//   frame high for exactly the bit periods of each word. Back-to-back words are
//   sent with no gap when the next load arrives during the last bit period.
//
// Parameters
//   WIDTH     word width in bits (>= 2)
//   MSB_FIRST 0: bit 0 goes out first, 1: bit WIDTH-1 goes out first
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   load      transmit request, taken when in_ready is high
//   data_in   word to transmit, sampled only on the accept edge
//   in_ready  combinational: a load on the next edge will be accepted
//   out_s     registered serial data
//   frame     registered: out_s carries a valid bit
//   done      registered one-cycle pulse after a word with no successor
//   overrun   registered sticky flag: load seen while in_ready was low
module parallel_to_serial #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  output logic             out_s,
  output logic             frame,
  output logic             done,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             out_d, frame_d, done_d, overrun_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      out_s   <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      cnt     <= cnt_d;
      out_s   <= out_d;
      frame   <= frame_d;
      done    <= done_d;
      overrun <= overrun_d;
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
    accept    = load & in_ready;
    state_d   = state;
    shreg_d   = shreg;
    cnt_d     = cnt;
    out_d     = out_s;
    frame_d   = frame;
    done_d    = 1'b0;
    overrun_d = overrun | (load & ~in_ready);

    if (accept) begin
      // The first bit goes straight to out_s; shreg keeps the rest with the
      // next bit already sitting at the output end.
      if (MSB_FIRST) begin
        out_d   = data_in[WIDTH-1];
        shreg_d = data_in << 1;
      end else begin
        out_d   = data_in[0];
        shreg_d = data_in >> 1;
      end
      cnt_d   = '0;
      frame_d = 1'b1;
      state_d = SHIFT;
    end else begin
      unique case (state)
        IDLE: begin
          out_d   = 1'b0;
          frame_d = 1'b0;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            out_d   = 1'b0;
            frame_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (MSB_FIRST) begin
              out_d   = shreg[WIDTH-1];
              shreg_d = shreg << 1;
            end else begin
              out_d   = shreg[0];
              shreg_d = shreg >> 1;
            end
            cnt_d = cnt + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
